// File: rtl/booth_muldiv_sequencer.sv
// booth_muldiv_sequencer
// Sequential signed MUL (radix-2 Booth) and DIV (restoring, magnitude based)
// unit. One bit is processed per clock. The 2W-bit result lands in HI/LO only
// on the edge that enters DONE, so partial results are never exposed.
module booth_muldiv_sequencer #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [WORD_SIZE-1:0] hi,
  output logic [WORD_SIZE-1:0] lo,
  output logic                 div_by_zero
);

  localparam int W  = WORD_SIZE;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_RUN = 3'd1,
    S_DIV_RUN = 3'd2,
    S_DIV_FIX = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Two's-complement magnitude; the most negative value maps to 2^(W-1) unsigned.
  function automatic logic [W-1:0] mag(input logic [W-1:0] x);
    mag = x[W-1] ? (W'(0) - x) : x;
  endfunction

  state_t          state_q,  state_d;
  logic [W:0]      acc_q,    acc_d;     // Booth accumulator A / division remainder R
  logic [W-1:0]    qr_q,     qr_d;      // Booth multiplier Q / division quotient Q
  logic            e_q,      e_d;       // Booth extra bit Q[-1]
  logic [W:0]      mcand_q,  mcand_d;   // sign-extended a (MUL) or |b| (DIV)
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic            a_neg_q,  a_neg_d;
  logic            b_neg_q,  b_neg_d;
  logic            dz_pend_q, dz_pend_d;
  logic [W-1:0]    hi_q,     hi_d;
  logic [W-1:0]    lo_q,     lo_d;
  logic            busy_q,   busy_d;
  logic            done_q,   done_d;
  logic            dbz_q,    dbz_d;

  logic            accept_s;
  logic [W:0]      booth_sum_s;
  logic [W:0]      div_shl_s;

  // Booth add/subtract selection and restoring-divide left shift of {R,Q}.
  always_comb begin
    booth_sum_s = acc_q;
    case ({qr_q[0], e_q})
      2'b01:   booth_sum_s = acc_q + mcand_q;
      2'b10:   booth_sum_s = acc_q - mcand_q;
      default: booth_sum_s = acc_q;
    endcase
    div_shl_s = {acc_q[W-1:0], qr_q[W-1]};
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    qr_d      = qr_q;
    e_d       = e_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    dz_pend_d = dz_pend_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    accept_s  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          dbz_d     = 1'b0;
          dz_pend_d = 1'b0;
          if (!op) begin
            state_d = S_MUL_RUN;
            acc_d   = '0;
            qr_d    = b;
            e_d     = 1'b0;
            mcand_d = {a[W-1], a};
            cnt_d   = CW'(W);
          end else if (b == '0) begin
            // Divide by zero skips iteration; DIV_FIX reports it next edge.
            state_d   = S_DIV_FIX;
            dz_pend_d = 1'b1;
            qr_d      = a;
          end else begin
            state_d = S_DIV_RUN;
            acc_d   = '0;
            qr_d    = mag(a);
            mcand_d = {1'b0, mag(b)};
            cnt_d   = CW'(W);
            a_neg_d = a[W-1];
            b_neg_d = b[W-1];
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_MUL_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          hi_d    = acc_q[W-1:0];
          lo_d    = qr_q;
        end else begin
          // Arithmetic right shift of {A,Q,E} after the add/subtract.
          acc_d = {booth_sum_s[W], booth_sum_s[W:1]};
          qr_d  = {booth_sum_s[0], qr_q[W-1:1]};
          e_d   = qr_q[0];
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DIV_RUN: begin
        if (cnt_q == '0) begin
          state_d = S_DIV_FIX;
        end else begin
          if (div_shl_s >= mcand_q) begin
            acc_d = div_shl_s - mcand_q;
            qr_d  = {qr_q[W-2:0], 1'b1};
          end else begin
            acc_d = div_shl_s;
            qr_d  = {qr_q[W-2:0], 1'b0};
          end
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DIV_FIX: begin
        state_d = S_DONE;
        if (dz_pend_q) begin
          hi_d  = qr_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          // Truncating division: quotient sign is the XOR, remainder follows a.
          lo_d = (a_neg_q ^ b_neg_q) ? (W'(0) - qr_q) : qr_q;
          hi_d = a_neg_q ? (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_MUL_RUN) || (state_d == S_DIV_RUN) || (state_d == S_DIV_FIX);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      qr_q      <= '0;
      e_q       <= 1'b0;
      mcand_q   <= '0;
      cnt_q     <= '0;
      a_neg_q   <= 1'b0;
      b_neg_q   <= 1'b0;
      dz_pend_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      qr_q      <= qr_d;
      e_q       <= e_d;
      mcand_q   <= mcand_d;
      cnt_q     <= cnt_d;
      a_neg_q   <= a_neg_d;
      b_neg_q   <= b_neg_d;
      dz_pend_q <= dz_pend_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_booth_muldiv_sequencer.sv
// Directed self-checking bench for booth_muldiv_sequencer (W = 32).
module tb_booth_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  booth_muldiv_sequencer #(.WORD_SIZE(32)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Present a request, let the next edge accept it, then scramble operands.
  task automatic do_start(input logic o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = $urandom_range(0, 1);
  endtask

  // Count edges until done; -1 if it never arrives within the budget.
  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (lat >= 100) begin lat = -1; break; end
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL reset_hilo got=%h_%h exp=0", hi, lo); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_mul_basic();
    int done_edge = -1;
    int busy_bad = 0;
    logic busy_at_done = 1'b1;
    do_start(1'b0, 32'd6, 32'd7);
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (e <= 32 && busy !== 1'b1) busy_bad++;
      if (done === 1'b1 && done_edge < 0) begin
        done_edge = e; busy_at_done = busy;
        n_cmp++; if (hi !== 32'h0) begin n_err++; $display("FAIL mul6x7_hi got=%h exp=00000000", hi); end
        n_cmp++; if (lo !== 32'h2A) begin n_err++; $display("FAIL mul6x7_lo got=%h exp=0000002a", lo); end
      end
      if (e == 34) begin
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL mul6x7_done_width got=%b exp=0", done); end
      end
    end
    n_cmp++; if (done_edge != 33) begin n_err++; $display("FAIL mul6x7_latency got=%0d exp=33", done_edge); end
    n_cmp++; if (busy_bad != 0) begin n_err++; $display("FAIL mul6x7_busy low_cycles=%0d exp=0", busy_bad); end
    n_cmp++; if (busy_at_done !== 1'b0) begin n_err++; $display("FAIL mul6x7_busy_at_done got=%b exp=0", busy_at_done); end
  endtask

  task automatic test_mul_signed();
    int lat;
    do_start(1'b0, 32'hFFFFFFFD, 32'd5);
    wait_done(lat);
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL mul_m3x5_latency got=%0d exp=33", lat); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin n_err++; $display("FAIL mul_m3x5 got=%h_%h exp=ffffffff_fffffff1", hi, lo); end
    do_start(1'b0, 32'h80000000, 32'h80000000);
    wait_done(lat);
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL mul_min_latency got=%0d exp=33", lat); end
    n_cmp++; if ({hi, lo} !== 64'h40000000_00000000) begin n_err++; $display("FAIL mul_minxmin got=%h_%h exp=40000000_00000000", hi, lo); end
  endtask

  task automatic test_div();
    int lat;
    do_start(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done(lat);
    n_cmp++; if (lat != 34) begin n_err++; $display("FAIL div_m7_2_latency got=%0d exp=34", lat); end
    n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL div_m7_2 got=%h_%h exp=ffffffff_fffffffd", hi, lo); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL div_m7_2_dbz got=%b exp=0", div_by_zero); end
    do_start(1'b1, 32'd100, 32'hFFFFFFF9);
    wait_done(lat);
    n_cmp++; if (lat != 34) begin n_err++; $display("FAIL div_100_m7_latency got=%0d exp=34", lat); end
    n_cmp++; if ({hi, lo} !== 64'h00000002_FFFFFFF2) begin n_err++; $display("FAIL div_100_m7 got=%h_%h exp=00000002_fffffff2", hi, lo); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL div_100_m7_dbz got=%b exp=0", div_by_zero); end
    do_start(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    n_cmp++; if ({hi, lo} !== 64'h00000000_80000000) begin n_err++; $display("FAIL div_min_m1 got=%h_%h exp=00000000_80000000", hi, lo); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL div_min_m1_dbz got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_div_zero();
    int lat;
    do_start(1'b1, 32'h12345678, 32'h0);
    wait_done(lat);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    n_cmp++; if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    n_cmp++; if ({hi, lo} !== 64'h12345678_FFFFFFFF) begin n_err++; $display("FAIL dbz_result got=%h_%h exp=12345678_ffffffff", hi, lo); end
    do_start(1'b0, 32'd2, 32'd3);
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL dbz_clear_on_accept got=%b exp=0", div_by_zero); end
    wait_done(lat);
    n_cmp++; if ({hi, lo} !== 64'h00000000_00000006) begin n_err++; $display("FAIL mul2x3 got=%h_%h exp=00000000_00000006", hi, lo); end
  endtask

  task automatic test_ignore_busy_start();
    int lat = -1;
    do_start(1'b0, 32'd6, 32'd7);
    for (int e = 1; e <= 40; e++) begin
      if (e == 10) begin start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd1; end
      @(posedge clk); #1;
      if (e == 10) start = 1'b0;
      if (done === 1'b1) begin lat = e; break; end
    end
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL ignore_latency got=%0d exp=33", lat); end
    n_cmp++; if ({hi, lo} !== 64'h00000000_0000002A) begin n_err++; $display("FAIL ignore_result got=%h_%h exp=00000000_0000002a", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    do_start(1'b0, 32'd5, 32'd5);
    wait_done(lat);
    // Still in the done cycle: the request is taken on the very next edge.
    do_start(1'b1, 32'd9, 32'd2);
    n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL b2b_accept busy_done got=%b exp=10", {busy, done}); end
    repeat (4) @(posedge clk);
    #1;
    n_cmp++; if ({hi, lo} !== 64'h00000000_00000019) begin n_err++; $display("FAIL b2b_hold got=%h_%h exp=00000000_00000019", hi, lo); end
    wait_done(lat);
    n_cmp++; if (lat != 30) begin n_err++; $display("FAIL b2b_latency got=%0d exp=30 (34 total)", lat); end
    n_cmp++; if ({hi, lo} !== 64'h00000001_00000004) begin n_err++; $display("FAIL b2b_div got=%h_%h exp=00000001_00000004", hi, lo); end
  endtask

  task automatic test_clr_abort();
    int done_seen = 0;
    do_start(1'b1, 32'd1000, 32'd3);
    repeat (14) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL clr_abort busy_done got=%b exp=00", {busy, done}); end
    n_cmp++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL clr_abort_hilo got=%h_%h exp=0", hi, lo); end
    for (int e = 0; e < 50; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_seen++;
    end
    n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL clr_no_done pulses=%0d exp=0", done_seen); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_signed();
    test_div();
    test_div_zero();
    test_ignore_busy_start();
    test_back_to_back();
    test_clr_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/booth_muldiv_sequencer.md
Name: booth_muldiv_sequencer

Overview:
Multi-cycle controller and datapath for the CPU's MUL and DIV instructions. It captures two signed operands on a start request and runs either a radix-2 Booth multiply or a restoring divide, one bit per clock. It returns a 2W-bit result split into HI and LO registers with a busy/done handshake, and sits beside the ALU feeding the HI/LO registers.

Parameters:
WORD_SIZE, 32, operand width W; HI and LO are each W bits

Ports:
clk  input  1  system clock, all state on rising edge
clr  input  1  synchronous, active-high reset
start  input  1  request; accepted only when busy=0
op  input  1  0 = MUL, 1 = DIV; sampled with start
a  input  W  signed multiplicand / dividend; sampled with start
b  input  W  signed multiplier / divisor; sampled with start
busy  output  1  operation in progress
done  output  1  one-cycle pulse; hi/lo valid from this cycle
hi  output  W  MUL: upper product word; DIV: remainder
lo  output  W  MUL: lower product word; DIV: quotient
div_by_zero  output  1  set with done when DIV had b=0; cleared on next accepted start

Behaviour:
- Reset (clr=1 at an edge): state=IDLE; busy, done, hi, lo, div_by_zero all 0. Reset aborts any operation in flight; no done is issued.
- States: IDLE, MUL_RUN, DIV_RUN, DIV_FIX, DONE.
- Accept: start=1 in IDLE or DONE. Latch a, b, op; clear div_by_zero; busy=1 next cycle. start while busy is ignored, with no queuing.
- Operand changes after acceptance have no effect.
- MUL_RUN datapath:
  - Accumulator A is W+1 bits, sign-extended so a = -2^(W-1) does not overflow. Q=b, E=0, counter=W.
  - Each cycle, {Q[0],E}=01 adds a to A; 10 subtracts a; 00/11 leaves A unchanged.
  - Then arithmetic right shift {A,Q,E} by 1; counter decrements.
  - At counter=0: hi=A[W-1:0], lo=Q; go to DONE.
- DIV_RUN datapath:
  - Restoring division on magnitudes |a| and |b| (W-bit unsigned; |-2^(W-1)| handled as unsigned 2^(W-1)).
  - W iterations: shift left {R,Q}; trial subtract |b| from R; keep if non-negative and set Q[0]=1, else restore.
- DIV_FIX (one cycle): quotient negated if sign(a) != sign(b); remainder takes the sign of a. Truncation is toward zero. Go to DONE.
- -2^(W-1) / -1 gives lo=0x80000000 (wrapped), hi=0; no flag.
- DIV with b=0: skip iteration and go to DONE next cycle with div_by_zero=1, hi=a, lo=all ones.
- Latency, in edges after the accepting edge until done=1: MUL W+1 (33); DIV W+2 (34); divide-by-zero 1.
- busy=1 from the cycle after acceptance through the last iteration/fix cycle; busy=0 in the done cycle.
- done is high for exactly one cycle (DONE state). DONE returns to IDLE, or directly re-accepts when start=1 is present in the DONE cycle.
- hi/lo change only on the edge entering DONE and hold until the next result or clr. Partial results are never visible on hi/lo.

Test Plan:
- Reset, then MUL a=6, b=7 -> done exactly 33 edges after start, busy high for cycles 1..32; hi=0x00000000, lo=0x0000002A.
- MUL a=-3, b=5, then a=0x80000000, b=0x80000000 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then hi=0x40000000, lo=0x00000000.
- DIV a=-7, b=2, then a=100, b=-7 -> done at edge 34 with lo=0xFFFFFFFD, hi=0xFFFFFFFF; then lo=0xFFFFFFF2, hi=0x00000002; div_by_zero=0 for both.
- DIV a=0x12345678, b=0 -> done at edge 1 after start with div_by_zero=1, hi=0x12345678, lo=0xFFFFFFFF. A following MUL 2×3 -> div_by_zero cleared at acceptance, lo=6.
- MUL 6×7 started; at edge 10 pulse start with op=DIV, b=1 -> ignored; result still lo=0x2A at edge 33. Start held high in the done cycle -> new operation accepted with no IDLE cycle.
- DIV started; clr=1 at edge 15 -> next cycle busy=0, done=0, hi=lo=0. No done pulse ever appears for the aborted operation.
